// File: rtl/paddle_ctrl_pkg.sv
// paddle_ctrl_pkg: key indices, line FSM encoding and position width shared by paddle_key_ctrl
package paddle_ctrl_pkg;
    localparam int KEY_LEFT   = 0;
    localparam int KEY_RIGHT  = 1;
    localparam int KEY_FAST   = 2;
    localparam int KEY_CENTRE = 3;
    localparam int POS_W      = 8;
    localparam int HCNT_W     = 9;
    typedef logic [POS_W-1:0] pos_t;
    typedef enum logic [1:0] {IDLE, COUNT, PULSE} line_state_e;
endpackage

// File: rtl/paddle_key_ctrl_key_debounce.sv
// key_debounce: 2-FF synchroniser plus stability debouncer for one key (debouncer only when PADDLE_KEY_DEBOUNCE_EN is defined)
module key_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_i,
    output logic key_o
);
    logic meta_q, sync_q;
    // two-stage synchroniser for the asynchronous key pin
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= key_i;
            sync_q <= meta_q;
        end
    end
`ifdef PADDLE_KEY_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic deb_q, deb_d, diff, hit;
    assign diff = sync_q != deb_q;
    assign hit  = cnt_q == CNT_W'(DEB_CYCLES - 1);
    // count cycles of disagreement; any agreement restarts the count
    always_comb begin
        cnt_d = (!diff || hit) ? '0 : cnt_q + 1'b1;
        deb_d = (diff && hit) ? sync_q : deb_q;
    end
    // debounce state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end
    assign key_o = deb_q;
`else
    assign key_o = sync_q;
`endif
endmodule

// File: rtl/paddle_key_ctrl.sv
// paddle_key_ctrl: keys -> per-frame paddle position -> per-line hpaddle pulse (key debouncing with PADDLE_KEY_DEBOUNCE_EN)
module paddle_key_ctrl
    import paddle_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 50000,
    parameter int H_BACK     = 23,
    parameter int PAD_MIN    = 0,
    parameter int PAD_MAX    = 224,
    parameter int PAD_RESET  = 112,
    parameter int STEP       = 2,
    parameter int FAST_STEP  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    input  logic [3:0]       keys,
    input  logic             hsync,
    input  logic             vsync,
    output logic             hpaddle,
    output logic [POS_W-1:0] paddle_pos
);
    logic [3:0] key_db;
    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key (
            .clk  (clk),
            .reset(reset),
            .key_i(keys[i]),
            .key_o(key_db[i])
        );
    end

    logic hs_q, vs_q, hs_fall, hs_rise, vs_rise;
    // core syncs are only meaningful on pixel enables
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else if (pix_en) begin
            hs_q <= hsync;
            vs_q <= vsync;
        end
    end
    assign hs_fall = pix_en && !hsync && hs_q;
    assign hs_rise = pix_en && hsync && !hs_q;
    assign vs_rise = pix_en && vsync && !vs_q;

    pos_t                     pos_q, pos_d;
    logic        [HCNT_W-1:0] step, pos_inc;
    logic signed [HCNT_W-1:0] pos_dec;
    assign step    = key_db[KEY_FAST] ? HCNT_W'(FAST_STEP) : HCNT_W'(STEP);
    assign pos_dec = $signed({1'b0, pos_q}) - $signed(step);
    assign pos_inc = {1'b0, pos_q} + step;
    // once-per-frame move: centre wins, then a single direction key, with clamping at both stops
    always_comb begin
        pos_d = pos_q;
        if (vs_rise) begin
            if (key_db[KEY_CENTRE])
                pos_d = POS_W'(PAD_RESET);
            else if (key_db[KEY_LEFT] && !key_db[KEY_RIGHT])
                pos_d = (pos_dec < $signed(HCNT_W'(PAD_MIN))) ? POS_W'(PAD_MIN) : pos_dec[POS_W-1:0];
            else if (key_db[KEY_RIGHT] && !key_db[KEY_LEFT])
                pos_d = (pos_inc > HCNT_W'(PAD_MAX)) ? POS_W'(PAD_MAX) : pos_inc[POS_W-1:0];
        end
    end
    // paddle position register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pos_q <= POS_W'(PAD_RESET);
        else       pos_q <= pos_d;
    end

    line_state_e       state_q, state_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_inc;
    pos_t              line_pos_q;
    logic              hcnt_max, hit;
    assign hcnt_inc = hcnt_q + 1'b1;
    assign hcnt_max = &hcnt_q;
    assign hit      = hcnt_inc == HCNT_W'(H_BACK) + {1'b0, line_pos_q};
    // line FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end
    // line FSM next state: count from hsync fall, pulse for one pixel, abort on hsync rise or counter saturation
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = hs_fall ? COUNT : IDLE;
            COUNT:   state_d = (hs_rise || (pix_en && hcnt_max)) ? IDLE : (pix_en && hit) ? PULSE : COUNT;
            PULSE:   state_d = pix_en ? IDLE : PULSE;
            default: state_d = IDLE;
        endcase
    end
    // line counter and the position latched for the whole line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q     <= '0;
            line_pos_q <= '0;
        end else if (state_q == IDLE && hs_fall) begin
            hcnt_q     <= '0;
            line_pos_q <= pos_q;
        end else if (state_q == COUNT && pix_en && !hcnt_max) begin
            hcnt_q     <= hcnt_inc;
        end
    end
    // outputs: pulse is high exactly while in PULSE
    always_comb begin
        hpaddle    = state_q == PULSE;
        paddle_pos = pos_q;
    end
endmodule

// File: tb/tb_paddle_key_ctrl.sv
// tb_paddle_key_ctrl: directed scoreboard bench for paddle_key_ctrl with DEB_CYCLES=4 and pix_en every 2nd clk
module tb_paddle_key_ctrl;
    logic       clk = 0, reset = 1, pix_en = 0, hsync = 0, vsync = 0;
    logic [3:0] keys = '0;
    logic       hpaddle;
    logic [7:0] paddle_pos;
    int         total = 0, bad = 0;
    int         exp_pos_q[$];
    int         exp_pulse_q[$];
    int         pos_m, hits;

    paddle_key_ctrl #(.DEB_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .keys      (keys),
        .hsync     (hsync),
        .vsync     (vsync),
        .hpaddle   (hpaddle),
        .paddle_pos(paddle_pos)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        pix_en = ~pix_en;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic next_pix();
        @(posedge clk);
        while (!pix_en) @(posedge clk);
        #1;
    endtask

    task automatic set_keys(input logic [3:0] k);
        keys = k;
        repeat (10) next_pix();
    endtask

    task automatic frame(input int exp);
        exp_pos_q.push_back(exp);
        vsync = 1;
        next_pix();
        check("frame_pos", paddle_pos, exp_pos_q.pop_front());
        repeat (2) next_pix();
        vsync = 0;
        repeat (2) next_pix();
    endtask

    task automatic run_line(input int exp, input int vs_at);
        int first = -1;
        int width = 0;
        exp_pulse_q.push_back(exp);
        hsync = 1;
        repeat (4) next_pix();
        hsync = 0;
        for (int i = 0; i < 260; i++) begin
            next_pix();
            if (hpaddle) begin
                if (first < 0) first = i;
                width++;
            end
            if (i == vs_at) vsync = 1;
            if (i == vs_at + 3) vsync = 0;
        end
        check("pulse_at", first, exp_pulse_q.pop_front());
        check("pulse_width", width, exp < 0 ? 0 : 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 0;
        check("rst_hpaddle", hpaddle, 0);
        check("rst_pos", paddle_pos, 112);

        set_keys(4'b0010);
        frame(114);
        frame(116);
        frame(118);
        set_keys(4'b0000);

        hsync = 1;
        repeat (4) next_pix();
        hsync = 0;
        repeat (40) next_pix();
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_hpaddle", hpaddle, 0);
        check("midrst_pos", paddle_pos, 112);
        reset = 0;
        hits = 0;
        repeat (250) begin
            next_pix();
            if (hpaddle) hits++;
        end
        check("no_pulse_after_rst", hits, 0);
        run_line(135, -1);

        pos_m = 112;
        set_keys(4'b0110);
        repeat (20) begin
            pos_m = (pos_m + 6 > 224) ? 224 : pos_m + 6;
            frame(pos_m);
        end
        check("top_sat", paddle_pos, 224);
        run_line(247, -1);

        set_keys(4'b1000);
        frame(112);
        pos_m = 112;
        set_keys(4'b0101);
        repeat (18) begin
            pos_m = (pos_m - 6 < 0) ? 0 : pos_m - 6;
            frame(pos_m);
        end
        check("at_four", paddle_pos, 4);
        frame(0);
        frame(0);
        run_line(23, -1);

        set_keys(4'b0010);
        frame(2);
        set_keys(4'b0011);
        frame(2);
        frame(2);
        set_keys(4'b0000);
        frame(2);

        pos_m = 2;
        set_keys(4'b0110);
        repeat (33) begin
            pos_m = (pos_m + 6 > 224) ? 224 : pos_m + 6;
            frame(pos_m);
        end
        check("at_200", paddle_pos, 200);
        set_keys(4'b1010);
        frame(112);

        set_keys(4'b0010);
        run_line(135, 50);
        check("midline_pos", paddle_pos, 114);
        set_keys(4'b0000);
        run_line(137, -1);

        keys = 4'b0010;
        @(posedge clk);
        @(posedge clk);
        #1;
        keys = 4'b0000;
        vsync = 1;
        next_pix();
`ifdef PADDLE_KEY_DEBOUNCE_EN
        check("glitch_pos", paddle_pos, 114);
`else
        check("glitch_pos", paddle_pos, 116);
`endif
        repeat (2) next_pix();
        vsync = 0;
        repeat (2) next_pix();
        check("end_hpaddle", hpaddle, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
